pixel_line_feeder: RTL and testbench
====================================

Name: pixel_line_feeder

Overview:
RTL pixel source for the 3x3 sharpen kernel's streaming input (inPixel/inPixelValid, flow-controlled by rdBuffEmpty). It replaces the bench-only feeding sequence with synthesizable logic that reads a frame from a synchronous frame memory. The sequence is: prime PRIME_LINES lines back-to-back, then send one line per rising edge of rdBuffEmpty until IMG_HEIGHT lines are sent. It sits between frame memory and the kernel top.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame.
- PRIME_LINES, 4, lines sent back-to-back after start (1..IMG_HEIGHT).
- ADDR_WIDTH, 18, frame memory address width (>= clog2(IMG_WIDTH*IMG_HEIGHT)).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- start  in  1  one-cycle frame start request
- memRdEn  out  1  frame memory read enable
- memAddr  out  ADDR_WIDTH  linear read address, row*IMG_WIDTH+col
- memData  in  DATA_WIDTH  read data, valid the cycle after memRdEn
- rdBuffEmpty  in  1  kernel line-buffer-empty flag; a rising edge requests one line
- outPixel  out  DATA_WIDTH  pixel to the kernel inPixel
- outPixelValid  out  1  to the kernel inPixelValid
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset (rst=0): all outputs 0, state IDLE, counters 0, pending flag 0. Applies immediately, including mid-frame; the frame is abandoned with no resume.
- States:
  - IDLE: start=1 -> PRIME; busy=1 next cycle.
  - PRIME: memRdEn=1 every cycle for PRIME_LINES*IMG_WIDTH cycles. Addresses run from 0 upward, incrementing by 1.
  - WAIT_EMPTY: memRdEn=0. Moves to LINE on (rdBuffEmpty rising edge OR pending=1); pending is cleared on that move.
  - LINE: memRdEn=1 for exactly IMG_WIDTH cycles, continuing the address sequence.
  - DONE: entered once line IMG_HEIGHT-1 is fully issued. Waits for the pipeline to drain, pulses done for 1 cycle, clears busy, returns to IDLE.
- After PRIME or LINE completes: if lines issued == IMG_HEIGHT go to DONE, else go to WAIT_EMPTY. PRIME_LINES == IMG_HEIGHT goes straight to DONE.
- Edge detection: registered copy of rdBuffEmpty; rise = rdBuffEmpty & ~prev. A level held high never retriggers.
- Rise during PRIME or LINE sets the one-deep pending flag. Further rises while pending=1 are dropped. Rises in IDLE/DONE are ignored.
- start while busy=1 is ignored.
- Latency: a read issued at cycle N has memData at N+1. outPixel/outPixelValid are registered and appear at N+2, so the output stream is gap-free within a line.
- outPixel holds its last value while outPixelValid=0.
- done asserts the cycle after the last outPixelValid=1.
- Counters:
  - col counter wraps IMG_WIDTH-1 -> 0 and increments the line counter.
  - Address counter never wraps within a frame; it resets to 0 at start.

Optional Feature:
PIXEL_LINE_FEEDER_TEST_PATTERN_EN.
- Defined: memData is ignored. outPixel = col[DATA_WIDTH-1:0] on priming lines and (col+1)[DATA_WIDTH-1:0] on subsequent lines. Timing, memRdEn and memAddr are unchanged. This is the kernel bring-up pattern.
- Undefined: outPixel is the registered memData.

Decomposition:
- Shared package/header pixel_feeder_pkg holds:
  - state encodings IDLE/PRIME/WAIT_EMPTY/LINE/DONE (3-bit);
  - localparams COL_W=clog2(IMG_WIDTH), ROW_W=clog2(IMG_HEIGHT+1), PRIME_PIX=PRIME_LINES*IMG_WIDTH.
- One natural sub-module: rise_edge_detect (registered edge detector, async active-low reset), used for rdBuffEmpty.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, PRIME_LINES=4, DATA_WIDTH=8, memory contents = address):
1. Hold rst=0 with random inputs -> all outputs 0. Release rst, with no start for 20 cycles -> busy=0, memRdEn=0.
2. start pulse -> memRdEn high for 32 consecutive cycles, addr 0..31. outPixelValid high for 32 cycles starting 2 cycles after the first memRdEn, outPixel 0..31. Then idle until rdBuffEmpty rises.
3. rdBuffEmpty 0->1, held high 50 cycles -> exactly 8 pixels (addr 32..39, outPixel 32..39) and no second line.
4. rdBuffEmpty pulses during PRIME -> line 4 (addr 32..39) starts the cycle after PRIME ends, with no gap. A second pulse during PRIME is dropped, so line 5 still needs a new rise.
5. After line 5 (last addr 47) -> done pulses 1 cycle after the last valid pixel and busy falls. A start issued mid-frame earlier had no effect. A fresh start restarts at addr 0.
6. rst=0 on the 3rd pixel of line 4 -> outPixelValid/memRdEn drop immediately. After release, the block sits in IDLE; start replays from addr 0. With TEST_PATTERN_EN: priming outPixel=0..7 per line, later lines 1..8.

Source files
------------

// File: rtl/pixel_feeder_pkg.sv
// pixel_feeder_pkg
//   Shared definitions for the pixel line feeder: FSM state encoding and
//   width helpers used to size the column/line counters from the frame
//   geometry parameters of pixel_line_feeder.
package pixel_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRIME      = 3'd1,
    WAIT_EMPTY = 3'd2,
    LINE       = 3'd3,
    DONE       = 3'd4
  } feederState_t;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value n itself.
  function automatic int unsigned cntWidth(input int unsigned n);
    return idxWidth(n + 1);
  endfunction

endpackage

// File: rtl/pixel_line_feeder_rise_edge_detect.sv
// rise_edge_detect
//   Registered rising-edge detector. A level held high produces a single
//   rise on its first cycle only.
// Ports:
//   clk   - rising-edge clock
//   rstN  - asynchronous active-low reset
//   level - input level to watch
//   rise  - high for the cycle where level is 1 and was 0 on the previous edge
module rise_edge_detect (
  input  logic clk,
  input  logic rstN,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder
//   Streams a frame from a synchronous frame memory into the sharpen kernel.
//   After start, PRIME_LINES lines are read back-to-back; each further line
//   is released by a rising edge of rdBuffEmpty until IMG_HEIGHT lines are
//   sent, then done pulses once the read pipeline has drained.
// Ports:
//   clk           - rising-edge clock
//   rst           - asynchronous active-low reset
//   start         - one-cycle frame start request (ignored while busy)
//   memRdEn       - frame memory read enable
//   memAddr       - linear read address row*IMG_WIDTH+col
//   memData       - read data, valid the cycle after memRdEn
//   rdBuffEmpty   - kernel line-buffer-empty flag; a rise requests a line
//   outPixel      - pixel to the kernel (holds while outPixelValid=0)
//   outPixelValid - pixel valid to the kernel
//   busy          - high from start acceptance until done
//   done          - one-cycle pulse after the last valid pixel
// Build option:
//   PIXEL_LINE_FEEDER_TEST_PATTERN_EN - outPixel becomes the bring-up
//   pattern (col on priming lines, col+1 afterwards); memData is ignored.
module pixel_line_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned ADDR_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  memRdEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  rdBuffEmpty,
  output logic [DATA_WIDTH-1:0] outPixel,
  output logic                  outPixelValid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned COL_W     = idxWidth(IMG_WIDTH);
  localparam int unsigned ROW_W     = cntWidth(IMG_HEIGHT);
  localparam int unsigned PRIME_PIX = PRIME_LINES * IMG_WIDTH;

  localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PRIME_LAST = ADDR_WIDTH'(PRIME_PIX - 1);
  localparam logic [ROW_W-1:0]      ROW_TOTAL  = ROW_W'(IMG_HEIGHT);

  feederState_t     state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] lineCnt;
  logic             pending;
  logic             emptyRise;
  logic             effPending;
  logic [ROW_W-1:0] lineNext;
  logic             burstEnd;
  logic             rdValid;

  rise_edge_detect uEmptyEdge (
    .clk   (clk),
    .rstN  (rst),
    .level (rdBuffEmpty),
    .rise  (emptyRise)
  );

  always_comb begin
    effPending = pending | emptyRise;
    lineNext   = lineCnt + ROW_W'(1);
    // PRIME ends on the last priming pixel, LINE on every column wrap.
    burstEnd   = (state == PRIME) ? (memAddr == PRIME_LAST) : (col == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      col     <= '0;
      lineCnt <= '0;
      pending <= 1'b0;
      memRdEn <= 1'b0;
      memAddr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= PRIME;
            busy    <= 1'b1;
            memRdEn <= 1'b1;
            memAddr <= '0;
            col     <= '0;
            lineCnt <= '0;
            pending <= 1'b0;
          end
        end

        PRIME, LINE: begin
          memAddr <= memAddr + ADDR_WIDTH'(1);
          if (col == COL_LAST) begin
            col     <= '0;
            lineCnt <= lineNext;
          end else begin
            col <= col + COL_W'(1);
          end

          if (burstEnd) begin
            pending <= 1'b0;
            if (lineNext == ROW_TOTAL) begin
              state   <= DONE;
              memRdEn <= 1'b0;
            end else if (effPending) begin
              // A request already seen chains the next line with no bubble.
              state   <= LINE;
              memRdEn <= 1'b1;
            end else begin
              state   <= WAIT_EMPTY;
              memRdEn <= 1'b0;
            end
          end else begin
            pending <= effPending;
          end
        end

        WAIT_EMPTY: begin
          if (effPending) begin
            state   <= LINE;
            memRdEn <= 1'b1;
            pending <= 1'b0;
          end
        end

        DONE: begin
          // Last read is in flight while rdValid=1; its pixel shows next cycle.
          if (!rdValid) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          memRdEn <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIXEL_LINE_FEEDER_TEST_PATTERN_EN
  logic [COL_W-1:0]      rdCol;
  logic                  rdPrime;
  logic [DATA_WIDTH-1:0] patternPix;

  always_comb begin
    patternPix = DATA_WIDTH'(rdCol) + (rdPrime ? '0 : DATA_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdValid       <= 1'b0;
      rdCol         <= '0;
      rdPrime       <= 1'b0;
      outPixel      <= '0;
      outPixelValid <= 1'b0;
    end else begin
      rdValid       <= memRdEn;
      rdCol         <= col;
      rdPrime       <= (lineCnt < ROW_W'(PRIME_LINES));
      outPixelValid <= rdValid;
      if (rdValid) outPixel <= patternPix;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdValid       <= 1'b0;
      outPixel      <= '0;
      outPixelValid <= 1'b0;
    end else begin
      rdValid       <= memRdEn;
      outPixelValid <= rdValid;
      if (rdValid) outPixel <= memData;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_line_feeder.sv
// tb_pixel_line_feeder
//   Directed bench for pixel_line_feeder with an 8x6 frame, 4 priming lines
//   and a frame memory whose contents equal the address.
module tb_pixel_line_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          rdBuffEmpty = 1'b0;
  logic          memRdEn;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData = '0;
  logic [DW-1:0] outPixel;
  logic          outPixelValid;
  logic          busy;
  logic          done;

  int checkCnt = 0;
  int failCnt  = 0;
  int cyc      = 0;

  int rdA[$];
  int rdC[$];
  int pxV[$];
  int pxC[$];
  int dnC[$];

  pixel_line_feeder #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (8),
    .IMG_HEIGHT  (6),
    .PRIME_LINES (4),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .memRdEn       (memRdEn),
    .memAddr       (memAddr),
    .memData       (memData),
    .rdBuffEmpty   (rdBuffEmpty),
    .outPixel      (outPixel),
    .outPixelValid (outPixelValid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous frame memory holding address as data.
  always @(posedge clk) begin
    if (memRdEn) memData <= memAddr[DW-1:0];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (memRdEn) begin
      rdA.push_back(int'(memAddr));
      rdC.push_back(cyc);
    end
    if (outPixelValid) begin
      pxV.push_back(int'(outPixel));
      pxC.push_back(cyc);
    end
    if (done) dnC.push_back(cyc);
  end

  function automatic int expPixel(input int addr);
`ifdef PIXEL_LINE_FEEDER_TEST_PATTERN_EN
    return ((addr / 8) < 4) ? (addr % 8) : (addr % 8) + 1;
`else
    return addr % 256;
`endif
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    rdA.delete(); rdC.delete(); pxV.delete(); pxC.delete(); dnC.delete();
  endtask

  task automatic startPulse();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulseEmpty();
    rdBuffEmpty = 1'b1; tick(1); rdBuffEmpty = 1'b0;
  endtask

  task automatic waitPix(input int n, input int budget, input string tag);
    int k = 0;
    while (pxV.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (pxV.size() < n) checkVal({tag, " timeout"}, pxV.size(), n);
  endtask

  // Reads must be contiguous from firstAddr, pixels exactly two cycles later.
  task automatic checkBurst(input string tag, input int firstAddr, input int n, input bit exact);
    if (exact) begin
      checkVal({tag, " reads"}, rdA.size(), n);
      checkVal({tag, " pixels"}, pxV.size(), n);
    end else begin
      checkVal({tag, " enough"}, (rdA.size() >= n && pxV.size() >= n), 1);
    end
    for (int i = 0; i < n; i++) begin
      if (i < rdA.size()) begin
        checkVal($sformatf("%s addr%0d", tag, i), rdA[i], firstAddr + i);
        checkVal($sformatf("%s rdgap%0d", tag, i), rdC[i] - rdC[0], i);
      end
      if (i < pxV.size()) begin
        checkVal($sformatf("%s pix%0d", tag, i), pxV[i], expPixel(firstAddr + i));
        if (i < rdC.size())
          checkVal($sformatf("%s lat%0d", tag, i), pxC[i] - rdC[i], 2);
      end
    end
  endtask

  task automatic runLine5(input string tag);
    clearLogs();
    tick(1);
    pulseEmpty();
    waitPix(8, 30, tag);
    tick(5);
    checkBurst(tag, 40, 8, 1'b1);
    checkVal({tag, " doneCount"}, dnC.size(), 1);
    if (dnC.size() > 0 && pxC.size() == 8)
      checkVal({tag, " doneTiming"}, dnC[0] - pxC[7], 1);
    checkVal({tag, " busyLow"}, busy, 0);
  endtask

  initial begin
    // Reset held with random inputs: everything quiet.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start       = 1'($urandom_range(0, 1));
      rdBuffEmpty = 1'($urandom_range(0, 1));
      #1;
      checkVal("resetOutputs",
               {memRdEn, memAddr, outPixel, outPixelValid, busy, done}, '0);
    end
    @(negedge clk);
    start = 1'b0; rdBuffEmpty = 1'b0; rst = 1'b1;
    tick(10);
    pulseEmpty();   // rise in IDLE must not leave a pending request
    tick(9);
    checkVal("idleBusy", busy, 0);
    checkVal("idleRdEn", memRdEn, 0);

    // Frame 1: priming burst, then wait for the kernel.
    clearLogs();
    startPulse();
    #1 checkVal("busyAfterStart", busy, 1);
    waitPix(32, 60, "prime");
    tick(10);
    checkBurst("prime", 0, 32, 1'b1);
    checkVal("waitRdEn", memRdEn, 0);
    checkVal("waitBusy", busy, 1);

    startPulse();   // ignored while busy
    tick(5);
    checkVal("midStartNoReads", rdA.size(), 32);
    checkVal("midStartBusy", busy, 1);

    // Level held high: exactly one line.
    clearLogs();
    rdBuffEmpty = 1'b1;
    tick(50);
    rdBuffEmpty = 1'b0;
    checkBurst("heldLine4", 32, 8, 1'b1);
    checkVal("heldNoDone", dnC.size(), 0);

    runLine5("f1line5");

    // Frame 2: two rises during PRIME, only one is kept.
    clearLogs();
    startPulse();
    tick(4);
    pulseEmpty();
    tick(6);
    pulseEmpty();
    waitPix(40, 80, "chain");
    tick(20);
    checkBurst("chain", 0, 40, 1'b1);
    checkVal("chainStopped", memRdEn, 0);
    runLine5("f2line5");

    // Frame 3: reset on the 3rd pixel of line 4.
    clearLogs();
    startPulse();
    tick(4);
    pulseEmpty();
    waitPix(35, 80, "abort");
    checkVal("abortValidBefore", outPixelValid, 1);
    rst = 1'b0;
    #1;
    checkVal("abortValid", outPixelValid, 0);
    checkVal("abortRdEn", memRdEn, 0);
    checkVal("abortBusy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(10);
    checkVal("postAbortRdEn", memRdEn, 0);
    checkVal("postAbortBusy", busy, 0);
    clearLogs();
    startPulse();
    waitPix(8, 30, "replay");
    checkBurst("replay", 0, 8, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule
